// File: rtl/trisc_pkg.sv
// ============================================================================
// Module      : trisc_pkg
// Description : Shared TRISC types and constants: fetch-controller state
//               codes, opcode values and instruction field positions.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package trisc_pkg;

  // The opcode occupies the top OPC_W bits of the instruction word.
  localparam int OPC_W   = 4;
  localparam int STATE_W = 3;

  localparam logic [OPC_W-1:0] OPC_JMP  = 4'h8;
  localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALTED  = 3'd4
  } state_e;

endpackage : trisc_pkg

`default_nettype wire

// File: rtl/trisc_fetch_ctrl_if.sv
// ============================================================================
// Module      : trisc_fetch_ctrl_if
// Description : Bundle between the fetch controller, the program counter
//               and the program ROM.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface trisc_fetch_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);

  logic              RUN;
  logic [ADDR_W-1:0] PC;
  logic [ADDR_W-1:0] ROM_ADDR;
  logic [DATA_W-1:0] ROM_DATA;
  logic [DATA_W-1:0] IR;
  logic              PC_INC;
  logic              PC_LOAD;
  logic [ADDR_W-1:0] PC_LOAD_VAL;
  logic              EXEC_STB;
  logic [2:0]        STATE;
  logic              HALTED;

  // Controller side.
  modport master (
    input  RUN, PC, ROM_DATA,
    output ROM_ADDR, IR, PC_INC, PC_LOAD, PC_LOAD_VAL, EXEC_STB, STATE, HALTED
  );

  // Counter / ROM / sequencing environment side.
  modport slave (
    output RUN, PC, ROM_DATA,
    input  ROM_ADDR, IR, PC_INC, PC_LOAD, PC_LOAD_VAL, EXEC_STB, STATE, HALTED
  );

endinterface : trisc_fetch_ctrl_if

`default_nettype wire

// File: rtl/trisc_fetch_ctrl.sv
// ============================================================================
// Module      : trisc_fetch_ctrl
// Description : FETCH/DECODE/EXECUTE sequencer with instruction register;
//               drives program-counter increment/load and stops on HALT.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module trisc_fetch_ctrl #(
  parameter int                              ADDR_W   = 4,
  parameter int                              DATA_W   = 8,
  parameter logic [trisc_pkg::OPC_W-1:0]     OPC_JMP  = trisc_pkg::OPC_JMP,
  parameter logic [trisc_pkg::OPC_W-1:0]     OPC_HALT = trisc_pkg::OPC_HALT
) (
  input  wire logic                CLK,
  input  wire logic                CLEAR,
  trisc_fetch_ctrl_if.master       bus
);

  import trisc_pkg::*;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              pc_inc_q, pc_inc_d;
  logic              pc_load_q, pc_load_d;
  logic              exec_stb_q, exec_stb_d;
  logic              halted_q, halted_d;
  logic [OPC_W-1:0]  opc;

  assign opc = ir_q[DATA_W-1 -: OPC_W];

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.RUN) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        ir_d    = bus.ROM_DATA;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = (opc == OPC_HALT) ? ST_HALTED : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        state_d = bus.RUN ? ST_FETCH : ST_IDLE;
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered images of the next state; EXECUTE is only
    // entered from DECODE, where IR is held, so opc is already final here.
    exec_stb_d = (state_d == ST_EXECUTE);
    pc_load_d  = exec_stb_d && (opc == OPC_JMP);
    pc_inc_d   = exec_stb_d && (opc != OPC_JMP);
    halted_d   = (state_d == ST_HALTED);
  end

  always_ff @(posedge CLK or negedge CLEAR) begin
    if (!CLEAR) begin
      state_q    <= ST_IDLE;
      ir_q       <= '0;
      pc_inc_q   <= 1'b0;
      pc_load_q  <= 1'b0;
      exec_stb_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      pc_inc_q   <= pc_inc_d;
      pc_load_q  <= pc_load_d;
      exec_stb_q <= exec_stb_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.ROM_ADDR    = bus.PC;
  assign bus.IR          = ir_q;
  assign bus.PC_INC      = pc_inc_q;
  assign bus.PC_LOAD     = pc_load_q;
  assign bus.PC_LOAD_VAL = ir_q[ADDR_W-1:0];
  assign bus.EXEC_STB    = exec_stb_q;
  assign bus.STATE       = state_q;
  assign bus.HALTED      = halted_q;

  always_ff @(posedge CLK) begin
    if (CLEAR) begin
      assert (!(pc_inc_q && pc_load_q));
    end
  end

endmodule : trisc_fetch_ctrl

`default_nettype wire

// File: tb/tb_trisc_fetch_ctrl.sv
// ============================================================================
// Module      : tb_trisc_fetch_ctrl
// Description : Bench for trisc_fetch_ctrl with a behavioural PC counter and
//               ROM; table-driven per-cycle expectations plus reset sequences.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_trisc_fetch_ctrl;

  logic clk;
  logic clear;
  logic [7:0] rom [16];
  logic [3:0] pc_m;
  logic       set_pc;
  logic [3:0] set_val;
  int n_pass;
  int n_total;

  typedef struct packed {
    logic       run;
    logic [2:0] st;
    logic [7:0] ir;
    logic       inc;
    logic       ld;
    logic       stb;
    logic       hlt;
    logic [3:0] pc;
  } vec_t;

  vec_t vq[$];

  trisc_fetch_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  trisc_fetch_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
    .CLK   (clk),
    .CLEAR (clear),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter as it sits upstream of the controller.
  always @(posedge clk or negedge clear) begin
    if (!clear)            pc_m <= 4'h0;
    else if (set_pc)       pc_m <= set_val;
    else if (bus.PC_INC)   pc_m <= pc_m + 4'h1;
    else if (bus.PC_LOAD)  pc_m <= bus.PC_LOAD_VAL;
  end

  assign bus.PC       = pc_m;
  assign bus.ROM_DATA = rom[bus.ROM_ADDR];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic run, input logic [2:0] st, input logic [7:0] ir,
                     input logic inc, input logic ld, input logic stb,
                     input logic hlt, input logic [3:0] pc);
    vec_t v;
    v = '{run: run, st: st, ir: ir, inc: inc, ld: ld, stb: stb, hlt: hlt, pc: pc};
    vq.push_back(v);
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, ".state"},    32'(bus.STATE),       32'(v.st));
    chk({tag, ".ir"},       32'(bus.IR),          32'(v.ir));
    chk({tag, ".pc_inc"},   32'(bus.PC_INC),      32'(v.inc));
    chk({tag, ".pc_load"},  32'(bus.PC_LOAD),     32'(v.ld));
    chk({tag, ".exec_stb"}, 32'(bus.EXEC_STB),    32'(v.stb));
    chk({tag, ".halted"},   32'(bus.HALTED),      32'(v.hlt));
    chk({tag, ".pc"},       32'(pc_m),            32'(v.pc));
    chk({tag, ".rom_addr"}, 32'(bus.ROM_ADDR),    32'(v.pc));
    chk({tag, ".load_val"}, 32'(bus.PC_LOAD_VAL), 32'(v.ir[3:0]));
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      bus.RUN = vq[i].run;
      tick();
      check_vec($sformatf("%s[%0d]", tag, i), vq[i]);
    end
    vq.delete();
  endtask

  task automatic do_reset();
    bus.RUN = 1'b0;
    clear   = 1'b0;
    tick();
    tick();
    clear = 1'b1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    set_pc  = 1'b0;
    set_val = 4'h0;
    clear_rom();

    // ---- reset state ----
    do_reset();
    check_vec("reset", '{run: 1'b0, st: 3'd0, ir: 8'h00, inc: 1'b0, ld: 1'b0,
                         stb: 1'b0, hlt: 1'b0, pc: 4'h0});

    // ---- sequential run, jump back to 1, pause in FETCH, resume ----
    rom[0] = 8'h12; rom[1] = 8'h34; rom[2] = 8'h56; rom[3] = 8'h81;
    //   run st  ir     inc ld stb hlt pc
    add(1, 1, 8'h00, 0, 0, 0, 0, 4'h0);
    add(1, 2, 8'h12, 0, 0, 0, 0, 4'h0);
    add(1, 3, 8'h12, 1, 0, 1, 0, 4'h0);
    add(1, 1, 8'h12, 0, 0, 0, 0, 4'h1);
    add(1, 2, 8'h34, 0, 0, 0, 0, 4'h1);
    add(1, 3, 8'h34, 1, 0, 1, 0, 4'h1);
    add(1, 1, 8'h34, 0, 0, 0, 0, 4'h2);
    add(1, 2, 8'h56, 0, 0, 0, 0, 4'h2);
    add(1, 3, 8'h56, 1, 0, 1, 0, 4'h2);
    add(1, 1, 8'h56, 0, 0, 0, 0, 4'h3);
    add(1, 2, 8'h81, 0, 0, 0, 0, 4'h3);
    add(1, 3, 8'h81, 0, 1, 1, 0, 4'h3);
    add(1, 1, 8'h81, 0, 0, 0, 0, 4'h1);
    add(0, 2, 8'h34, 0, 0, 0, 0, 4'h1);
    add(0, 3, 8'h34, 1, 0, 1, 0, 4'h1);
    add(0, 0, 8'h34, 0, 0, 0, 0, 4'h2);
    add(0, 0, 8'h34, 0, 0, 0, 0, 4'h2);
    add(1, 1, 8'h34, 0, 0, 0, 0, 4'h2);
    add(1, 2, 8'h56, 0, 0, 0, 0, 4'h2);
    add(1, 3, 8'h56, 1, 0, 1, 0, 4'h2);
    add(1, 1, 8'h56, 0, 0, 0, 0, 4'h3);
    add(1, 2, 8'h81, 0, 0, 0, 0, 4'h3);
    run_table("seq");

    // ---- asynchronous reset in the middle of FETCH ----
    bus.RUN = 1'b1;
    tick();
    tick();
    chk("pre_rst.state", 32'(bus.STATE), 32'd1);
    #2;
    clear = 1'b0;
    #1;
    check_vec("async_rst", '{run: 1'b1, st: 3'd0, ir: 8'h00, inc: 1'b0, ld: 1'b0,
                             stb: 1'b0, hlt: 1'b0, pc: 4'h0});
    tick();
    bus.RUN = 1'b0;
    clear   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_vec($sformatf("idle_hold[%0d]", i),
                '{run: 1'b0, st: 3'd0, ir: 8'h00, inc: 1'b0, ld: 1'b0,
                  stb: 1'b0, hlt: 1'b0, pc: 4'h0});
    end

    // ---- HALT: freeze, RUN ignored, CLEAR exits ----
    clear_rom();
    rom[0] = 8'h12; rom[1] = 8'h34; rom[2] = 8'hF0;
    add(1, 1, 8'h00, 0, 0, 0, 0, 4'h0);
    add(1, 2, 8'h12, 0, 0, 0, 0, 4'h0);
    add(1, 3, 8'h12, 1, 0, 1, 0, 4'h0);
    add(1, 1, 8'h12, 0, 0, 0, 0, 4'h1);
    add(1, 2, 8'h34, 0, 0, 0, 0, 4'h1);
    add(1, 3, 8'h34, 1, 0, 1, 0, 4'h1);
    add(1, 1, 8'h34, 0, 0, 0, 0, 4'h2);
    add(1, 2, 8'hF0, 0, 0, 0, 0, 4'h2);
    add(1, 4, 8'hF0, 0, 0, 0, 1, 4'h2);
    add(0, 4, 8'hF0, 0, 0, 0, 1, 4'h2);
    add(1, 4, 8'hF0, 0, 0, 0, 1, 4'h2);
    add(0, 4, 8'hF0, 0, 0, 0, 1, 4'h2);
    add(1, 4, 8'hF0, 0, 0, 0, 1, 4'h2);
    run_table("halt");
    #2;
    clear = 1'b0;
    #1;
    chk("halt_clr.state",  32'(bus.STATE),  32'd0);
    chk("halt_clr.halted", 32'(bus.HALTED), 32'd0);
    chk("halt_clr.ir",     32'(bus.IR),     32'h00);
    bus.RUN = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    chk("halt_after.state", 32'(bus.STATE), 32'd0);

    // ---- wrap-around from PC=F ----
    clear_rom();
    rom[15] = 8'h20; rom[0] = 8'h12;
    set_val = 4'hF;
    set_pc  = 1'b1;
    tick();
    set_pc  = 1'b0;
    add(1, 1, 8'h00, 0, 0, 0, 0, 4'hF);
    add(1, 2, 8'h20, 0, 0, 0, 0, 4'hF);
    add(1, 3, 8'h20, 1, 0, 1, 0, 4'hF);
    add(1, 1, 8'h20, 0, 0, 0, 0, 4'h0);
    add(1, 2, 8'h12, 0, 0, 0, 0, 4'h0);
    run_table("wrap");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_trisc_fetch_ctrl

`default_nettype wire
